icache_axi_reader: RTL and testbench

//  Responder for the instruction-cache refill request: accepts inst_cache_req/addr from

---
 rtl/icache_axi_reader.sv | 142 ++++++++++++++
 tb/tb_icache_axi_reader.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_axi_reader.sv
// Instruction-cache refill reader: turns a held refill request into one single-beat AXI3 read
// and returns the word with a one-cycle dok pulse, suppressed if the request went stale.
module icache_axi_reader #(
  parameter logic [3:0] AXI_ID  = 4'd0,
  parameter logic [3:0] ARCACHE = 4'd0
) (
  input  logic        clk,
  input  logic        resetn,
  // instr_cache side
  input  logic        inst_cache_req,
  input  logic [31:0] inst_cache_addr,
  output logic [31:0] inst_cache_rdata,
  output logic        inst_cache_dok,
  output logic        inst_cache_err,
  // AXI3 read address channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // AXI3 read data channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [1:0] {StIdle, StAr, StR} state_e;

  state_e      r_state, w_state_next;
  logic        r_arvalid, w_arvalid_next;
  logic        r_rready, w_rready_next;
  logic [31:0] r_araddr, w_araddr_next;
  logic [31:0] r_rdata, w_rdata_next;
  logic        r_dok, w_dok_next;
  logic        r_err, w_err_next;
  logic        r_stale, w_stale_next;

  logic w_abort;
  logic w_stale_now;
  logic w_beat;
  logic w_unused;

  // A flush or redirect in the current cycle counts immediately, so a beat landing in the
  // same cycle as the change is never reported to the cache.
  assign w_abort     = !inst_cache_req || (inst_cache_addr[31:2] != r_araddr[31:2]);
  assign w_stale_now = r_stale || w_abort;
  assign w_beat      = rvalid && r_rready && (rid == AXI_ID);

  // rlast is not needed: with arlen=0 every accepted beat is the only beat.
  assign w_unused = ^{rlast, inst_cache_addr[1:0]};

  always_comb begin
    w_state_next   = r_state;
    w_arvalid_next = r_arvalid;
    w_rready_next  = r_rready;
    w_araddr_next  = r_araddr;
    w_rdata_next   = r_rdata;
    w_dok_next     = 1'b0;
    w_err_next     = 1'b0;
    w_stale_next   = r_stale;

    case (r_state)
      StIdle: begin
        if (inst_cache_req) begin
          w_araddr_next  = {inst_cache_addr[31:2], 2'b00};
          w_arvalid_next = 1'b1;
          w_stale_next   = 1'b0;
          w_state_next   = StAr;
        end
      end
      StAr: begin
        w_stale_next = w_stale_now;
        if (r_arvalid && arready) begin
          w_arvalid_next = 1'b0;
          w_rready_next  = 1'b1;
          w_state_next   = StR;
        end
      end
      StR: begin
        w_stale_next = w_stale_now;
        if (w_beat) begin
          w_rdata_next  = rdata;
          w_rready_next = 1'b0;
          w_dok_next    = !w_stale_now;
          w_err_next    = !w_stale_now && (rresp != 2'b00);
          w_state_next  = StIdle;
        end
      end
      default: begin
        w_arvalid_next = 1'b0;
        w_rready_next  = 1'b0;
        w_state_next   = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= StIdle;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_araddr  <= 32'd0;
      r_rdata   <= 32'd0;
      r_dok     <= 1'b0;
      r_err     <= 1'b0;
      r_stale   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_arvalid <= w_arvalid_next;
      r_rready  <= w_rready_next;
      r_araddr  <= w_araddr_next;
      r_rdata   <= w_rdata_next;
      r_dok     <= w_dok_next;
      r_err     <= w_err_next;
      r_stale   <= w_stale_next;
    end
  end

  assign inst_cache_rdata = r_rdata;
  assign inst_cache_dok   = r_dok;
  assign inst_cache_err   = r_err;

  assign arid    = AXI_ID;
  assign araddr  = r_araddr;
  assign arlen   = 4'd0;
  assign arsize  = 3'd2;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = ARCACHE;
  assign arprot  = 3'b000;
  assign arvalid = r_arvalid;
  assign rready  = r_rready;

endmodule

// File: tb/tb_icache_axi_reader.sv
// Bench for icache_axi_reader: task-driven AXI slave stimulus with a dok scoreboard.
module tb_icache_axi_reader;

  logic        clk;
  logic        resetn;
  logic        inst_cache_req;
  logic [31:0] inst_cache_addr;
  logic [31:0] inst_cache_rdata;
  logic        inst_cache_dok;
  logic        inst_cache_err;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  icache_axi_reader dut (
    .clk              (clk),
    .resetn           (resetn),
    .inst_cache_req   (inst_cache_req),
    .inst_cache_addr  (inst_cache_addr),
    .inst_cache_rdata (inst_cache_rdata),
    .inst_cache_dok   (inst_cache_dok),
    .inst_cache_err   (inst_cache_err),
    .arid             (arid),
    .araddr           (araddr),
    .arlen            (arlen),
    .arsize           (arsize),
    .arburst          (arburst),
    .arlock           (arlock),
    .arcache          (arcache),
    .arprot           (arprot),
    .arvalid          (arvalid),
    .arready          (arready),
    .rid              (rid),
    .rdata            (rdata),
    .rresp            (rresp),
    .rlast            (rlast),
    .rvalid           (rvalid),
    .rready           (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every dok must match the oldest expected refill result.
  always @(negedge clk) begin
    if (resetn && inst_cache_dok) begin
      exp_t e;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_dok: got dok=1 rdata=%h, required no dok", inst_cache_rdata);
      end else begin
        e = sb_q.pop_front();
        if (inst_cache_rdata !== e.data || inst_cache_err !== e.err) begin
          failures++;
          $display("FAIL sb_result: got rdata=%h err=%b, required rdata=%h err=%b",
                   inst_cache_rdata, inst_cache_err, e.data, e.err);
        end
      end
    end
  end

  // mode 0: normal; 1: req drops once in R; 2: addr changes to alt_addr in AR (needs ar_stall>0)
  task automatic refill(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp,
                        input int ar_stall, input int bad_beats, input int mode,
                        input logic [31:0] alt_addr, input string name);
    int          edges;
    bit          ok;
    bit          exp_dok;
    logic [31:0] exp_addr;
    exp_addr = {addr[31:2], 2'b00};
    exp_dok  = (mode == 0);
    if (exp_dok) sb_q.push_back('{data: data, err: (resp != 2'b00)});
    inst_cache_req  = 1'b1;
    inst_cache_addr = addr;
    edges = 0;
    ok    = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      edges++;
      if (arvalid) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_arvalid_timeout: got arvalid=0, required arvalid=1", name);
      inst_cache_req = 1'b0;
      return;
    end
    checks++;
    if (araddr !== exp_addr || arlen !== 4'd0 || arsize !== 3'd2 || arburst !== 2'b01 ||
        arid !== 4'd0 || arcache !== 4'd0 || arprot !== 3'd0 || arlock !== 2'b00) begin
      failures++;
      $display("FAIL %s_ar_fields: got araddr=%h arlen=%h arsize=%h arburst=%b, required %h 0 2 01",
               name, araddr, arlen, arsize, arburst, exp_addr);
    end
    for (int i = 0; i < ar_stall; i++) begin
      if (mode == 2 && i == 0) inst_cache_addr = alt_addr;
      @(posedge clk); #1;
      edges++;
      checks++;
      if (arvalid !== 1'b1 || araddr !== exp_addr) begin
        failures++;
        $display("FAIL %s_ar_stable: got arvalid=%b araddr=%h, required 1 %h",
                 name, arvalid, araddr, exp_addr);
      end
    end
    arready = 1'b1;
    @(posedge clk); #1;
    edges++;
    arready = 1'b0;
    checks++;
    if (arvalid !== 1'b0 || rready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ar_handshake: got arvalid=%b rready=%b, required 0 1", name, arvalid, rready);
    end
    if (mode == 1) inst_cache_req = 1'b0;
    for (int i = 0; i < bad_beats; i++) begin
      rvalid = 1'b1;
      rid    = 4'h3;
      rdata  = ~data;
      rresp  = 2'b00;
      rlast  = 1'b1;
      @(posedge clk); #1;
      edges++;
      rvalid = 1'b0;
      checks++;
      if (rready !== 1'b1 || inst_cache_dok !== 1'b0) begin
        failures++;
        $display("FAIL %s_bad_rid: got rready=%b dok=%b, required 1 0", name, rready, inst_cache_dok);
      end
    end
    rvalid = 1'b1;
    rid    = 4'h0;
    rdata  = data;
    rresp  = resp;
    rlast  = 1'b1;
    @(posedge clk); #1;
    edges++;
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
    checks++;
    if (inst_cache_dok !== exp_dok || rready !== 1'b0 || arvalid !== 1'b0) begin
      failures++;
      $display("FAIL %s_beat: got dok=%b rready=%b arvalid=%b, required dok=%b rready=0 arvalid=0",
               name, inst_cache_dok, rready, arvalid, exp_dok);
    end
    if (exp_dok) begin
      checks++;
      if (edges != 3 + ar_stall + bad_beats || inst_cache_rdata !== data ||
          inst_cache_err !== (resp != 2'b00)) begin
        failures++;
        $display("FAIL %s_result: got latency=%0d rdata=%h err=%b, required %0d %h %b", name, edges,
                 inst_cache_rdata, inst_cache_err, 3 + ar_stall + bad_beats, data, resp != 2'b00);
      end
    end
    if (mode != 2) inst_cache_req = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #1;
    checks++;
    if (arvalid !== 1'b0 || rready !== 1'b0 || araddr !== 32'd0 || inst_cache_rdata !== 32'd0 ||
        inst_cache_dok !== 1'b0 || inst_cache_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: got arvalid=%b rready=%b araddr=%h rdata=%h dok=%b err=%b, required 0",
               arvalid, rready, araddr, inst_cache_rdata, inst_cache_dok, inst_cache_err);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic test_basic();
    refill(32'hBFC0_0004, 32'h2408_0001, 2'b00, 0, 0, 0, 32'h0, "basic");
    @(posedge clk); #1;
    checks++;
    if (inst_cache_dok !== 1'b0 || inst_cache_rdata !== 32'h2408_0001) begin
      failures++;
      $display("FAIL basic_pulse: got dok=%b rdata=%h, required 0 24080001",
               inst_cache_dok, inst_cache_rdata);
    end
  endtask

  task automatic test_ar_stall();
    refill(32'h8000_1233, 32'hDEAD_BEEF, 2'b00, 5, 0, 0, 32'h0, "ar_stall");
  endtask

  task automatic test_drop_in_r();
    refill(32'h0000_0040, 32'h1111_2222, 2'b00, 0, 0, 1, 32'h0, "drop_in_r");
  endtask

  task automatic test_redirect();
    refill(32'h0000_0100, 32'h3333_4444, 2'b00, 2, 0, 2, 32'h0000_0200, "redirect_old");
    refill(32'h0000_0200, 32'h5555_6666, 2'b00, 0, 0, 0, 32'h0, "redirect_new");
  endtask

  task automatic test_err();
    refill(32'h1FC0_0010, 32'hCAFE_F00D, 2'b10, 1, 0, 0, 32'h0, "err_resp");
  endtask

  task automatic test_bad_rid();
    refill(32'h0000_3000, 32'h7777_8888, 2'b00, 0, 2, 0, 32'h0, "bad_rid");
  endtask

  task automatic test_async_reset();
    inst_cache_req  = 1'b1;
    inst_cache_addr = 32'h0000_0500;
    arready         = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (arvalid !== 1'b0 || rready !== 1'b0 || araddr !== 32'd0) begin
      failures++;
      $display("FAIL async_reset: got arvalid=%b rready=%b araddr=%h, required 0 0 0",
               arvalid, rready, araddr);
    end
    inst_cache_req = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    refill(32'h0000_0600, 32'h9999_AAAA, 2'b00, 0, 0, 0, 32'h0, "after_reset");
  endtask

  task automatic test_back_to_back();
    refill(32'h0000_0700, 32'h0102_0304, 2'b00, 0, 0, 0, 32'h0, "b2b_a");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (arvalid !== 1'b0) begin
        failures++;
        $display("FAIL b2b_no_dup: got arvalid=%b, required 0", arvalid);
      end
    end
    refill(32'h0000_0800, 32'h0506_0708, 2'b01, 0, 0, 0, 32'h0, "b2b_b");
    refill(32'h0000_0804, 32'h090A_0B0C, 2'b00, 1, 1, 0, 32'h0, "b2b_c");
  endtask

  initial begin
    inst_cache_req  = 1'b0;
    inst_cache_addr = 32'h0;
    arready         = 1'b0;
    rid             = 4'h0;
    rdata           = 32'h0;
    rresp           = 2'b00;
    rlast           = 1'b0;
    rvalid          = 1'b0;
    resetn          = 1'b0;
    test_reset();
    test_basic();
    test_ar_stall();
    test_drop_in_r();
    test_redirect();
    test_err();
    test_bad_rid();
    test_async_reset();
    test_back_to_back();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d pending results, required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
